// File: rtl/gpmc_sync_master.sv
// gpmc_sync_master
//   Synchronous-mode, muxed address/data GPMC initiator. A host request on the
//   valid/ready port becomes one GPMC access: an ADDR phase, then either a
//   one-period WRITE or an RD_LATENCY-period READ, and finally RECOVERY periods
//   with chip select released. gpmc_clk is clk/2. Every bus output is
//   registered and changes only on the clk edge where gpmc_clk falls, which
//   gives the responder half a gpmc_clk period of setup and hold around its
//   rising-edge sample point.
//
// Ports
//   clk, reset                  system clock, asynchronous active-high reset
//   req, req_is_wr, addr,       host request; captured when req & req_ready
//   wr_data
//   req_ready                   high while idle and able to accept
//   rd_data, rd_valid           read result, one-clk valid pulse
//   wr_done                     one-clk pulse when the write data phase ends
//   gpmc_clk                    free-running GPMC clock (clk/2)
//   gpmc_cs_n/adv_n/we_n/oe_n   active-low GPMC strobes
//   gpmc_ad_o, gpmc_ad_oe,      AD bus output value, output enable and input;
//   gpmc_ad_i                   the tri-state buffer lives in the top level
module gpmc_sync_master #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 8,
  parameter int RECOVERY   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  req_is_wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  req_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  wr_done,
  output logic                  gpmc_clk,
  output logic                  gpmc_cs_n,
  output logic                  gpmc_adv_n,
  output logic                  gpmc_we_n,
  output logic                  gpmc_oe_n,
  output logic [15:0]           gpmc_ad_o,
  output logic                  gpmc_ad_oe,
  input  logic [15:0]           gpmc_ad_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_WRITE, S_READ, S_RECOVER
  } state_t;

  localparam logic [7:0] WAIT_LOAD = 8'(RD_LATENCY - 1);
  localparam logic [3:0] REC_LOAD  = 4'(RECOVERY - 1);

  state_t                r_state, w_state_nxt;
  logic                  r_gclk;
  logic                  w_fall, w_rise, w_accept;
  logic [7:0]            r_wait, w_wait_nxt;
  logic [3:0]            r_rec, w_rec_nxt;
  logic                  r_is_wr;
  logic [ADDR_WIDTH-2:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid, r_wr_done;
  logic                  r_cs_n, r_adv_n, r_we_n, r_oe_n, r_ad_oe;
  logic [15:0]           r_ad_o;
  logic                  w_rd_valid, w_wr_done;
  logic                  w_cs_n, w_adv_n, w_we_n, w_oe_n, w_ad_oe;
  logic [15:0]           w_ad_o;
  logic                  w_unused_addr0;

  // Byte address bit 0 never reaches the 16-bit bus.
  assign w_unused_addr0 = addr[0];

  // r_gclk is the level before this edge: 1 means gpmc_clk falls at this edge.
  assign w_fall   = r_gclk;
  assign w_rise   = ~r_gclk;
  assign w_accept = req & r_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_rec_nxt   = r_rec;
    w_rd_valid  = 1'b0;
    w_wr_done   = 1'b0;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = S_START;
      // START only waits for the next falling edge so ADDR is aligned to it.
      S_START:   if (w_fall) w_state_nxt = S_ADDR;
      S_ADDR: begin
        if (w_fall) begin
          w_state_nxt = r_is_wr ? S_WRITE : S_READ;
          w_wait_nxt  = WAIT_LOAD;
        end
      end
      S_WRITE: begin
        if (w_fall) begin
          w_state_nxt = S_RECOVER;
          w_rec_nxt   = REC_LOAD;
          w_wr_done   = 1'b1;
        end
      end
      S_READ: begin
        if (w_fall) begin
          if (r_wait == 8'd0) begin
            w_state_nxt = S_RECOVER;
            w_rec_nxt   = REC_LOAD;
            w_rd_valid  = 1'b1;
          end else begin
            w_wait_nxt = r_wait - 8'd1;
          end
        end
      end
      S_RECOVER: begin
        if (w_fall) begin
          if (r_rec == 4'd0) w_state_nxt = S_IDLE;
          else               w_rec_nxt   = r_rec - 4'd1;
        end
      end
      default:   w_state_nxt = S_IDLE;
    endcase

    // Bus values are decoded from the next state; since every bus-visible
    // state change happens on a falling tick, the registered bus only moves there.
    w_cs_n  = 1'b1;
    w_adv_n = 1'b1;
    w_we_n  = 1'b1;
    w_oe_n  = 1'b1;
    w_ad_oe = 1'b0;
    w_ad_o  = 16'h0000;
    case (w_state_nxt)
      S_ADDR: begin
        w_cs_n  = 1'b0;
        w_adv_n = 1'b0;
        w_ad_oe = 1'b1;
        w_ad_o  = 16'(r_addr);
      end
      S_WRITE: begin
        w_cs_n  = 1'b0;
        w_we_n  = 1'b0;
        w_ad_oe = 1'b1;
        w_ad_o  = 16'(r_wdata);
      end
      S_READ: begin
        w_cs_n = 1'b0;
        w_oe_n = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gclk     <= 1'b0;
      r_state    <= S_IDLE;
      r_wait     <= 8'd0;
      r_rec      <= 4'd0;
      r_is_wr    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ready    <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_wr_done  <= 1'b0;
      r_cs_n     <= 1'b1;
      r_adv_n    <= 1'b1;
      r_we_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_ad_oe    <= 1'b0;
      r_ad_o     <= 16'h0000;
    end else begin
      r_gclk     <= ~r_gclk;
      r_state    <= w_state_nxt;
      r_wait     <= w_wait_nxt;
      r_rec      <= w_rec_nxt;
      r_ready    <= (w_state_nxt == S_IDLE);
      r_rd_valid <= w_rd_valid;
      r_wr_done  <= w_wr_done;
      r_cs_n     <= w_cs_n;
      r_adv_n    <= w_adv_n;
      r_we_n     <= w_we_n;
      r_oe_n     <= w_oe_n;
      r_ad_oe    <= w_ad_oe;
      r_ad_o     <= w_ad_o;
      if (w_accept) begin
        r_is_wr <= req_is_wr;
        r_addr  <= addr[ADDR_WIDTH-1:1];
        r_wdata <= wr_data;
      end
      // Sample on the gpmc_clk rising edge that closes the last READ period.
      if (r_state == S_READ && r_wait == 8'd0 && w_rise)
        r_rd_data <= gpmc_ad_i;
    end
  end

  assign gpmc_clk   = r_gclk;
  assign req_ready  = r_ready;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign wr_done    = r_wr_done;
  assign gpmc_cs_n  = r_cs_n;
  assign gpmc_adv_n = r_adv_n;
  assign gpmc_we_n  = r_we_n;
  assign gpmc_oe_n  = r_oe_n;
  assign gpmc_ad_oe = r_ad_oe;
  assign gpmc_ad_o  = r_ad_o;

endmodule

// File: tb/tb_gpmc_sync_master.sv
// tb_gpmc_sync_master
//   Two instances: dut0 with default timing (RD_LATENCY=8, RECOVERY=2) and
//   dut1 with RD_LATENCY=1, RECOVERY=1. Each has a small GPMC responder memory.
//   Stimulus pushes the expected completion into a per-instance queue; a
//   separate monitor process acts as responder, checks bus rules every cycle
//   and pops/compares whenever rd_valid or wr_done is seen.
module tb_gpmc_sync_master;

  typedef struct packed {
    logic        wr;
    logic [15:0] wa;
    logic [15:0] d;
  } exp_t;

  logic        clk;
  logic        rst    [2];
  logic        req    [2];
  logic        is_wr  [2];
  logic [16:0] addr_v [2];
  logic [15:0] wdata  [2];
  logic        rdy    [2];
  logic [15:0] rdata  [2];
  logic        rvld   [2];
  logic        wdone  [2];
  logic        gclk   [2];
  logic        cs_n   [2];
  logic        adv_n  [2];
  logic        we_n   [2];
  logic        oe_n   [2];
  logic [15:0] ad_o   [2];
  logic        ad_oe  [2];
  logic [15:0] ad_i   [2];

  for (genvar g = 0; g < 2; g++) begin : gd
    gpmc_sync_master #(
      .ADDR_WIDTH(17),
      .DATA_WIDTH(16),
      .RD_LATENCY(g == 0 ? 8 : 1),
      .RECOVERY  (g == 0 ? 2 : 1)
    ) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .req       (req[g]),
      .req_is_wr (is_wr[g]),
      .addr      (addr_v[g]),
      .wr_data   (wdata[g]),
      .req_ready (rdy[g]),
      .rd_data   (rdata[g]),
      .rd_valid  (rvld[g]),
      .wr_done   (wdone[g]),
      .gpmc_clk  (gclk[g]),
      .gpmc_cs_n (cs_n[g]),
      .gpmc_adv_n(adv_n[g]),
      .gpmc_we_n (we_n[g]),
      .gpmc_oe_n (oe_n[g]),
      .gpmc_ad_o (ad_o[g]),
      .gpmc_ad_oe(ad_oe[g]),
      .gpmc_ad_i (ad_i[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_bad;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] mem      [2][256];
  logic [15:0] refb     [8];
  logic [20:0] prev_bus [2];
  bit          prev_ok  [2];
  bit          prev_acc [2];
  logic [15:0] raddr    [2];
  logic [15:0] rword    [2];
  logic [15:0] lastwd   [2];
  int          n_we     [2];
  int          n_oe     [2];
  int          n_adv    [2];
  int          n_acc    [2];
  int          cs_hi    [2];

  function automatic int lat_of(input int g);
    return (g == 0) ? 8 : 1;
  endfunction

  function automatic int rec_of(input int g);
    return (g == 0) ? 2 : 1;
  endfunction

  function automatic int qsize(input int g);
    return (g == 0) ? q0.size() : q1.size();
  endfunction

  task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got 0x%0h, want 0x%0h at %0t", nm, g, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm, input int g);
    n_cmp++;
    n_bad++;
    $display("FAIL %s dut%0d at %0t", nm, g, $time);
  endtask

  task automatic push(input int g, input exp_t e);
    if (g == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic pop(input int g, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '0;
    if (g == 0) begin
      if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
    end else begin
      if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
    end
  endtask

  task automatic monitor();
    logic [20:0] bus;
    exp_t        e;
    bit          ok;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        bus = {cs_n[g], adv_n[g], we_n[g], oe_n[g], ad_oe[g], ad_o[g]};
        if (rst[g]) begin
          prev_ok[g]  = 1'b0;
          prev_acc[g] = 1'b0;
          ad_i[g]     = 16'h0;
        end else begin
          // gclk high here means the previous clk edge was a gpmc_clk rise.
          if (prev_ok[g] && gclk[g]) chk("bus_moved_off_fall", g, bus, prev_bus[g]);
          prev_bus[g] = bus;
          prev_ok[g]  = 1'b1;
          chk("we_oe_both_low", g, (!we_n[g] && !oe_n[g]), 0);
          if (!adv_n[g]) chk("adv_without_cs", g, cs_n[g], 0);
          if (!oe_n[g])  chk("ad_driven_in_read", g, ad_oe[g], 0);
          if (gclk[g]) begin
            if (!cs_n[g] && !adv_n[g]) begin
              raddr[g] = ad_o[g];
              rword[g] = mem[g][ad_o[g][7:0]];
              n_we[g]  = 0;
              n_oe[g]  = 0;
              n_adv[g]++;
            end
            if (!cs_n[g] && !we_n[g]) begin
              chk("ad_oe_in_write", g, ad_oe[g], 1);
              mem[g][raddr[g][7:0]] = ad_o[g];
              lastwd[g] = ad_o[g];
              n_we[g]++;
            end
            if (!oe_n[g]) n_oe[g]++;
            if (cs_n[g]) begin
              cs_hi[g]++;
            end else if (cs_hi[g] != 0) begin
              chk("recovery_gap_ok", g, (cs_hi[g] >= rec_of(g)), 1);
              cs_hi[g] = 0;
            end
          end
          ad_i[g] = oe_n[g] ? 16'h0 : rword[g];
          if (prev_acc[g]) chk("ready_drop_after_accept", g, rdy[g], 0);
          prev_acc[g] = req[g] && rdy[g];
          if (prev_acc[g]) n_acc[g]++;
          if (wdone[g] || rvld[g]) begin
            pop(g, e, ok);
            if (!ok) fail("unexpected_completion", g);
            else begin
              chk("done_kind", g, {wdone[g], rvld[g]}, e.wr ? 2'b10 : 2'b01);
              chk("addr_phase_value", g, raddr[g], e.wa);
              if (e.wr) begin
                chk("write_data", g, lastwd[g], e.d);
                chk("we_low_rises", g, n_we[g], 1);
              end else begin
                chk("read_data", g, rdata[g], e.d);
                chk("oe_low_periods", g, n_oe[g], lat_of(g));
                chk("we_in_read", g, n_we[g], 0);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic issue(input int g, input bit wr, input logic [16:0] a, input logic [15:0] d,
                       input logic [15:0] exp_d, input bit hold);
    exp_t e;
    int   t;
    e.wr = wr;
    e.wa = a[16:1];
    e.d  = exp_d;
    @(posedge clk);
    #1;
    req[g]    = 1'b1;
    is_wr[g]  = wr;
    addr_v[g] = a;
    wdata[g]  = d;
    push(g, e);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rdy[g] && t < 400);
    if (!rdy[g]) fail("accept_timeout", g);
    @(posedge clk);
    #1;
    if (!hold) req[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(qsize(g) == 0 && rdy[g]) && t < 400);
    if (!(qsize(g) == 0 && rdy[g])) fail("idle_timeout", g);
  endtask

  initial begin
    logic [15:0] d;
    int          w;
    bit          wr;
    int          t;
    n_cmp = 0;
    n_bad = 0;
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; req[g] = 1'b0; is_wr[g] = 1'b0; addr_v[g] = '0; wdata[g] = '0;
      ad_i[g] = 16'h0; prev_ok[g] = 1'b0; prev_acc[g] = 1'b0; prev_bus[g] = '0;
      raddr[g] = '0; rword[g] = '0; lastwd[g] = '0;
      n_we[g] = 0; n_oe[g] = 0; n_adv[g] = 0; n_acc[g] = 0; cs_hi[g] = 100;
      for (int i = 0; i < 256; i++) mem[g][i] = 16'h0000;
    end
    for (int i = 0; i < 8; i++) refb[i] = 16'h0000;
    mem[0][8'h08] = 16'h1234;

    fork
      monitor();
    join_none

    #23;
    for (int g = 0; g < 2; g++) begin
      chk("reset_values", g,
          {gclk[g], cs_n[g], adv_n[g], we_n[g], oe_n[g], ad_oe[g], ad_o[g], rdata[g], rvld[g], wdone[g], rdy[g]},
          {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0});
      rst[g] = 1'b0;
    end
    #1;
    chk("ready_before_first_edge", 0, rdy[0], 0);
    @(posedge clk);
    #1;
    chk("ready_after_first_edge", 0, rdy[0], 1);
    chk("ready_after_first_edge", 1, rdy[1], 1);

    // Single write: ADDR carries 0x0124>>1 = 0x0092, data 0xBEEF.
    issue(0, 1'b1, 17'h00124, 16'hBEEF, 16'hBEEF, 1'b0);
    wait_idle(0);
    // Single read of preloaded word 0x0008.
    issue(0, 1'b0, 17'h00010, 16'h0000, 16'h1234, 1'b0);
    wait_idle(0);
    // Back-to-back with req held: write then read the same word.
    issue(0, 1'b1, 17'h00002, 16'h0001, 16'h0001, 1'b1);
    issue(0, 1'b0, 17'h00002, 16'h0000, 16'h0001, 1'b0);
    wait_idle(0);

    // Reset in the 4th gpmc_clk period of a read.
    issue(0, 1'b0, 17'h00010, 16'h0000, 16'h1234, 1'b0);
    t = 0;
    while (oe_n[0] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (oe_n[0]) fail("oe_never_low", 0);
    repeat (3) @(posedge gclk[0]);
    @(negedge gclk[0]);
    #3;
    rst[0] = 1'b1;
    #1;
    chk("reset_mid_read_bus", 0,
        {gclk[0], cs_n[0], adv_n[0], we_n[0], oe_n[0], ad_oe[0], ad_o[0], rvld[0], wdone[0], rdy[0]},
        {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});
    q0.delete();
    #20;
    rst[0] = 1'b0;
    issue(0, 1'b0, 17'h00010, 16'h0000, 16'h1234, 1'b0);
    wait_idle(0);

    // req toggled while not ready during a write must be ignored.
    issue(0, 1'b1, 17'h00040, 16'h5A5A, 16'h5A5A, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      req[0]   = ~req[0];
      is_wr[0] = 1'($urandom_range(0, 1));
    end
    req[0] = 1'b0;
    wait_idle(0);
    issue(0, 1'b0, 17'h00040, 16'h0000, 16'h5A5A, 1'b0);
    wait_idle(0);

    // Short-timing instance: 16 random accesses over 8 words.
    for (int i = 0; i < 16; i++) begin
      wr = 1'($urandom_range(0, 1));
      w  = $urandom_range(0, 7);
      d  = 16'($urandom);
      if (wr) refb[w] = d;
      issue(1, wr, 17'(w * 2), d, wr ? d : refb[w], 1'b0);
    end
    wait_idle(1);

    chk("accepted_requests", 0, n_acc[0], 8);
    chk("accepted_requests", 1, n_acc[1], 16);
    chk("addr_phases_per_accept", 0, n_adv[0], n_acc[0]);
    chk("addr_phases_per_accept", 1, n_adv[1], n_acc[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
